// File: rtl/msk_unmask_pkg.sv
// Shared definitions for the masked-stream unmasking block: FSM encodings and
// the word-counter width helper.
package msk_unmask_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    UNMASK  = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Bits needed to index n slots; callers guarantee n >= 2 so the result is >= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/msk_unmask_stream_if.sv
// Handshake bundle for msk_unmask_stream: masked word stream in, unmasked block out.
// master = producer/consumer side, slave = the unmasking block.
interface msk_unmask_stream_if #(
  parameter int d      = 2,
  parameter int count  = 32,
  parameter int nwords = 4
);

  logic [count*d-1:0]      in_shares;
  logic                    in_valid;
  logic                    in_ready;
  logic [count*nwords-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_shares, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_shares, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/msk_recombine.sv
// Combinational share recombination: each output bit is the XOR of its d shares,
// taken from the interleaved layout where bit i share j sits at index i*d+j.
module msk_recombine #(
  parameter int d     = 2,
  parameter int count = 32
) (
  input  logic [count*d-1:0] shares,
  output logic [count-1:0]   bits
);

  for (genvar gi = 0; gi < count; gi++) begin : g_bit
    assign bits[gi] = ^shares[gi*d +: d];
  end

endmodule

// File: rtl/msk_unmask_stream.sv
// Collects nwords masked words, recombines all shares in one step and presents
// the unmasked block. Optional macro MSK_UNMASK_CLEAR_EN wipes buffer and output after use.
module msk_unmask_stream
  import msk_unmask_pkg::*;
#(
  parameter int d      = 2,
  parameter int count  = 32,
  parameter int nwords = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [count*d-1:0]      in_shares,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [count*nwords-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int WW = clog2(nwords);

`ifdef MSK_UNMASK_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  state_t                  state_reg, state_next;
  logic [WW-1:0]           wcnt_reg, wcnt_next;
  logic                    unmask_done_reg, unmask_done_next;
  logic [count*d-1:0]      share_buf [nwords];
  logic [count*nwords-1:0] out_data_reg;
  logic [count*nwords-1:0] recombined;
  logic                    accept;
  logic                    load_out;
  logic                    clear_buf;
  logic                    clear_out;

  // Shares stay separate in the buffer; they only meet inside the recombiners,
  // whose result is captured solely while in UNMASK.
  for (genvar gi = 0; gi < nwords; gi++) begin : g_word
    msk_recombine #(
      .d     (d),
      .count (count)
    ) u_recombine (
      .shares (share_buf[gi]),
      .bits   (recombined[gi*count +: count])
    );
  end

  assign in_ready  = (state_reg == COLLECT);
  assign out_valid = (state_reg == OUTPUT);
  assign out_data  = out_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= COLLECT;
      wcnt_reg        <= '0;
      unmask_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wcnt_reg        <= wcnt_next;
      unmask_done_reg <= unmask_done_next;
    end
  end

  // UNMASK spans two cycles: capture the recombined block, then hand over,
  // so the block appears two edges after the last word is accepted.
  always_comb begin
    state_next       = state_reg;
    wcnt_next        = wcnt_reg;
    unmask_done_next = unmask_done_reg;
    accept           = 1'b0;
    load_out         = 1'b0;
    clear_buf        = 1'b0;
    clear_out        = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (in_valid) begin
          accept = 1'b1;
          if (wcnt_reg == WW'(nwords - 1)) begin
            wcnt_next        = '0;
            unmask_done_next = 1'b0;
            state_next       = UNMASK;
          end else begin
            wcnt_next = wcnt_reg + 1'b1;
          end
        end
      end
      UNMASK: begin
        if (!unmask_done_reg) begin
          load_out         = 1'b1;
          unmask_done_next = 1'b1;
        end else begin
          clear_buf        = 1'b1;
          unmask_done_next = 1'b0;
          state_next       = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          clear_out  = 1'b1;
          state_next = COLLECT;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (CLEAR_EN && clear_buf && !rst) begin
      for (int k = 0; k < nwords; k++) begin
        share_buf[k] <= '0;
      end
    end else if (accept && !rst) begin
      share_buf[wcnt_reg] <= in_shares;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg <= '0;
    end else if (load_out) begin
      out_data_reg <= recombined;
    end else if (CLEAR_EN && clear_out) begin
      out_data_reg <= '0;
    end
  end

endmodule

// File: tb/tb_msk_unmask_stream.sv
// Directed self-checking bench for msk_unmask_stream (d=2 and d=3 instances),
// expectations follow MSK_UNMASK_CLEAR_EN when defined.
module tb_msk_unmask_stream;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  msk_unmask_stream_if #(.d(2), .count(32), .nwords(4)) b2 ();
  msk_unmask_stream_if #(.d(3), .count(32), .nwords(4)) b3 ();

  msk_unmask_stream #(.d(2), .count(32), .nwords(4)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_shares (b2.in_shares),
    .in_valid  (b2.in_valid),
    .in_ready  (b2.in_ready),
    .out_data  (b2.out_data),
    .out_valid (b2.out_valid),
    .out_ready (b2.out_ready)
  );

  msk_unmask_stream #(.d(3), .count(32), .nwords(4)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_shares (b3.in_shares),
    .in_valid  (b3.in_valid),
    .in_ready  (b3.in_ready),
    .out_data  (b3.out_data),
    .out_valid (b3.out_valid),
    .out_ready (b3.out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mask2(input logic [31:0] v, input logic [31:0] m);
    logic [63:0] r;
    for (int i = 0; i < 32; i++) begin
      r[2*i]   = m[i];
      r[2*i+1] = m[i] ^ v[i];
    end
    return r;
  endfunction

  function automatic logic [95:0] mask3(input logic [31:0] v, input logic [31:0] m1,
                                        input logic [31:0] m2);
    logic [95:0] r;
    for (int i = 0; i < 32; i++) begin
      r[3*i]   = m1[i];
      r[3*i+1] = m2[i];
      r[3*i+2] = m1[i] ^ m2[i] ^ v[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [63:0] sh);
    checks++;
    if (b2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send2_ready: in_ready=%b expected 1", b2.in_ready);
    end
    b2.in_shares = sh;
    b2.in_valid  = 1'b1;
    tick();
    b2.in_valid  = 1'b0;
  endtask

  task automatic send3(input logic [95:0] sh);
    checks++;
    if (b3.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send3_ready: in_ready=%b expected 1", b3.in_ready);
    end
    b3.in_shares = sh;
    b3.in_valid  = 1'b1;
    tick();
    b3.in_valid  = 1'b0;
  endtask

  task automatic handshake2();
    b2.out_ready = 1'b1;
    tick();
    b2.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    b2.in_valid  = 1'b1;
    b2.in_shares = mask2(32'h77, 32'h1234_5678);
    b2.out_ready = 1'b1;
    tick();
    tick();
    rst          = 1'b0;
    b2.in_valid  = 1'b0;
    b2.out_ready = 1'b0;
    checks++;
    if (b2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", b2.in_ready);
    end
    checks++;
    if (b2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", b2.out_valid);
    end
    checks++;
    if (b2.out_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_out_data: got %h expected 0", b2.out_data);
    end
    $display("reset: in_ready=%b out_valid=%b out_data=%h", b2.in_ready, b2.out_valid, b2.out_data);
  endtask

  task automatic test_basic();
    logic [127:0] exp;
    exp = 128'h00000004_00000003_00000002_00000001;
    for (int k = 0; k < 4; k++) begin
      send2(mask2(32'(k + 1), 32'h1111_1111));
    end
    checks++;
    if (b2.out_valid !== 1'b0 || b2.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_lat_t0: out_valid=%b in_ready=%b expected 0 0", b2.out_valid, b2.in_ready);
    end
    tick();
    checks++;
    if (b2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_lat_t1: out_valid=%b expected 0", b2.out_valid);
    end
    tick();
    checks++;
    if (b2.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_lat_t2: out_valid=%b expected 1", b2.out_valid);
    end
    checks++;
    if (b2.out_data !== exp) begin
      errors++;
      $display("FAIL basic_data: got %h expected %h", b2.out_data, exp);
    end
    $display("basic: out_valid=%b out_data=%h", b2.out_valid, b2.out_data);
    handshake2();
    checks++;
    if (b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_hs: in_ready=%b out_valid=%b expected 1 0", b2.in_ready, b2.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp;
    logic [63:0]  sh0;
    logic [63:0]  exp_buf;
    logic [127:0] exp_after;
    exp = 128'h00000008_00000007_00000006_00000005;
    sh0 = mask2(32'h5, 32'hA5A5_5A5A);
    send2(sh0);
    for (int k = 1; k < 4; k++) begin
      send2(mask2(32'(k + 5), 32'hA5A5_5A5A));
    end
    tick();
    tick();
    b2.out_ready = 1'b0;
`ifdef MSK_UNMASK_CLEAR_EN
    exp_buf   = 64'h0;
    exp_after = 128'h0;
`else
    exp_buf   = sh0;
    exp_after = exp;
`endif
    checks++;
    if (u_dut2.share_buf[0] !== exp_buf) begin
      errors++;
      $display("FAIL bp_share_buf: got %h expected %h", u_dut2.share_buf[0], exp_buf);
    end
    for (int c = 0; c < 5; c++) begin
      b2.in_valid  = 1'b1;
      b2.in_shares = mask2(32'hBAD0 + 32'(c), 32'h0F0F_0F0F);
      tick();
      checks++;
      if (b2.out_valid !== 1'b1 || b2.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_ctrl: cycle %0d out_valid=%b in_ready=%b expected 1 0", c, b2.out_valid, b2.in_ready);
      end
      checks++;
      if (b2.out_data !== exp) begin
        errors++;
        $display("FAIL bp_hold_data: cycle %0d got %h expected %h", c, b2.out_data, exp);
      end
      $display("backpressure: cycle %0d out_valid=%b in_ready=%b out_data=%h", c, b2.out_valid, b2.in_ready, b2.out_data);
    end
    b2.in_valid = 1'b0;
    handshake2();
    checks++;
    if (b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_hs: in_ready=%b out_valid=%b expected 1 0", b2.in_ready, b2.out_valid);
    end
    checks++;
    if (b2.out_data !== exp_after) begin
      errors++;
      $display("FAIL bp_out_after: got %h expected %h", b2.out_data, exp_after);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] exp;
    exp = 128'h0000000D_0000000C_0000000B_0000000A;
    send2(mask2(32'h55, 32'h3C3C_3C3C));
    send2(mask2(32'h66, 32'h3C3C_3C3C));
    rst          = 1'b1;
    b2.in_valid  = 1'b1;
    b2.in_shares = mask2(32'h99, 32'h3C3C_3C3C);
    tick();
    rst         = 1'b0;
    b2.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send2(mask2(32'hA + 32'(k), 32'h6969_9696));
    end
    tick();
    tick();
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== exp) begin
      errors++;
      $display("FAIL reset_mid_data: out_valid=%b got %h expected 1 %h", b2.out_valid, b2.out_data, exp);
    end
    $display("reset_mid: out_valid=%b out_data=%h", b2.out_valid, b2.out_data);
    handshake2();
  endtask

  task automatic test_back_to_back();
    logic [63:0]  w [8];
    logic [127:0] exp [2];
    int           idx;
    int           blk;
    int           gap;
    logic         acc;
    for (int k = 0; k < 8; k++) begin
      w[k] = mask2(32'h100 + 32'(k), $urandom);
      exp[k/4][(k%4)*32 +: 32] = 32'h100 + 32'(k);
    end
    idx = 0;
    blk = 0;
    gap = 0;
    for (int c = 0; c < 60 && blk < 2; c++) begin
      b2.out_ready = 1'b1;
      b2.in_valid  = 1'b1;
      b2.in_shares = (idx < 8) ? w[idx] : 64'h0;
      acc = b2.in_ready && (idx < 8);
      if (!b2.in_ready && idx < 8) gap++;
      if (idx >= 8) b2.in_valid = 1'b0;
      tick();
      if (acc) idx++;
      if (b2.out_valid === 1'b1) begin
        checks++;
        if (b2.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_in_ready: block %0d in_ready=%b expected 0", blk, b2.in_ready);
        end
        checks++;
        if (b2.out_data !== exp[blk]) begin
          errors++;
          $display("FAIL b2b_data: block %0d got %h expected %h", blk, b2.out_data, exp[blk]);
        end
        $display("back_to_back: block %0d out_data=%h", blk, b2.out_data);
        blk++;
      end
    end
    b2.in_valid = 1'b0;
    tick();
    b2.out_ready = 1'b0;
    checks++;
    if (blk != 2 || idx != 8) begin
      errors++;
      $display("FAIL b2b_blocks: blocks=%0d words=%0d expected 2 8", blk, idx);
    end
    checks++;
    if (gap != 3) begin
      errors++;
      $display("FAIL b2b_gap: in_ready low cycles=%0d expected 3", gap);
    end
    checks++;
    if (b2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end_ready: in_ready=%b expected 1", b2.in_ready);
    end
  endtask

  task automatic test_d3();
    logic [127:0] exp;
    exp = {4{32'hDEADBEEF}};
    for (int k = 0; k < 4; k++) begin
      send3(mask3(32'hDEADBEEF, $urandom, $urandom));
    end
    tick();
    tick();
    checks++;
    if (b3.out_valid !== 1'b1 || b3.out_data !== exp) begin
      errors++;
      $display("FAIL d3_data: out_valid=%b got %h expected 1 %h", b3.out_valid, b3.out_data, exp);
    end
    $display("d3: out_valid=%b out_data=%h", b3.out_valid, b3.out_data);
    b3.out_ready = 1'b1;
    tick();
    b3.out_ready = 1'b0;
    checks++;
    if (b3.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL d3_after_hs: in_ready=%b expected 1", b3.in_ready);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    b2.in_shares = '0;
    b2.in_valid  = 1'b0;
    b2.out_ready = 1'b0;
    b3.in_shares = '0;
    b3.in_valid  = 1'b0;
    b3.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_d3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msk_unmask_stream.md
MSK_UNMASK_STREAM -- requirements
Module: msk_unmask_stream

Interface
REQ-001 SHALL have parameter d, default 2: number of shares per bit (d >= 2).
REQ-002 SHALL have parameter count, default 32: bits per input word.
REQ-003 SHALL have parameter nwords, default 4: words per block (nwords >= 2).
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in_shares, input, count*d: masked word; bit i share j at index i*d+j.
REQ-007 SHALL have port in_valid, input, 1: in_shares valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts a word.
REQ-009 SHALL have port out_data, output, count*nwords: unmasked block.
REQ-010 SHALL have port out_valid, output, 1: out_data valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_data.

Function
REQ-012 SHALL implement FSM states COLLECT, UNMASK, OUTPUT.
REQ-013 SHALL drive in_ready=1 only in COLLECT; out_valid=1 only in OUTPUT.
REQ-014 SHALL, in COLLECT, store in_shares unrecombined into share buffer slot wcnt on in_valid&in_ready, then increment wcnt.
REQ-015 SHALL wrap wcnt from nwords-1 to 0 and go to UNMASK on acceptance of word nwords-1.
REQ-016 SHALL, in UNMASK, register the XOR of all d shares of every buffered bit into out_data and go to OUTPUT next cycle.
REQ-017 SHALL map first accepted word to out_data[count-1:0], word k to out_data[(k+1)*count-1:k*count].
REQ-018 SHALL give latency: last word accepted at edge t -> out_valid high after edge t+2.
REQ-019 SHALL hold out_data and out_valid stable in OUTPUT until out_ready=1; then go to COLLECT next edge.
REQ-020 SHALL not bypass: in_ready rises only the cycle after the output handshake, even if in_valid is high.
REQ-021 SHALL ignore in_shares and in_valid outside COLLECT; no word is lost or duplicated.
REQ-022 SHALL never combine shares of a bit before UNMASK (no unmasked value in share buffer or wcnt path).

Reset
REQ-023 SHALL, on rst=1 at an edge, enter COLLECT, set wcnt=0, out_valid=0, in_ready=1 after the edge, out_data=0.
REQ-024 SHALL abandon any partial block on reset mid-collection; next accepted word is word 0.
REQ-025 SHALL give rst priority over every handshake in the same cycle.

Configuration
REQ-026 SHALL support macro MSK_UNMASK_CLEAR_EN.
REQ-027 SHALL, with MSK_UNMASK_CLEAR_EN defined, zero the share buffer in UNMASK->OUTPUT transition and zero out_data on output handshake; out_data=0 in COLLECT.
REQ-028 SHALL, without MSK_UNMASK_CLEAR_EN, leave share buffer and out_data unchanged after use.

Structure
REQ-029 SHALL place FSM state encodings (2-bit) and the wcnt width function clog2(nwords) in shared package msk_unmask_pkg.
REQ-030 SHALL use one sub-module msk_recombine (parameters d, count): combinational XOR of d shares per bit.

Verification
REQ-031 d=2: 4 words, shares (0x11111111, 0x11111110) etc. for values 1,2,3,4 -> out_data=0x00000004_00000003_00000002_00000001 two cycles after last accept.
REQ-032 out_ready held 0 for 5 cycles -> out_data/out_valid stable, in_ready=0, extra in_valid words not accepted.
REQ-033 rst after 2 words, then 4 words values 0xA..0xD -> out_data=0x0000000D_0000000C_0000000B_0000000A.
REQ-034 in_valid continuously high across two blocks, out_ready=1 -> in_ready low in UNMASK, OUTPUT; second block correct, no word lost.
REQ-035 d=3, random shares of 0xDEADBEEF per word -> every out_data word=0xDEADBEEF.
REQ-036 MSK_UNMASK_CLEAR_EN defined -> share buffer all-zero during OUTPUT, out_data=0 after handshake; undefined -> retained.
